// File: rtl/i4004_pkg.sv
// Shared encodings for the 4004 bus controller: CPU subcycle numbering and
// clock slot numbering within one CPU period.
package i4004_pkg;

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cyc_t;

    typedef enum logic [1:0] {
        SLOT_S0 = 2'd0,
        SLOT_S1 = 2'd1,
        SLOT_S2 = 2'd2,
        SLOT_S3 = 2'd3
    } slot_t;

endpackage

// File: rtl/i4004_clkgen.sv
// Two-phase CPU clock generator: four slots of PHASE_LEN cycles (phi1, gap, phi2, gap).
// Registered phi outputs; stall holds the last cycle of S3 so both phases stay low.
module i4004_clkgen
    import i4004_pkg::*;
#(
    parameter int PHASE_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic phi1,
    output logic phi2,
    output logic phi1_rise,
    output logic phi2_rise
);

    localparam logic [7:0] LAST = 8'(PHASE_LEN - 1);

    slot_t      slot_q;
    logic [7:0] cnt_q;
    logic       run_q;
    logic       last;

    assign last = (cnt_q == LAST);

    // Strobes announce that the coming edge raises the corresponding phase.
    assign phi2_rise = run_q && (slot_q == SLOT_S1) && last;
    assign phi1_rise = run_q && (slot_q == SLOT_S3) && last && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            slot_q <= SLOT_S0;
            cnt_q  <= 8'd0;
            phi1   <= 1'b0;
            phi2   <= 1'b0;
        end else if (!run_q) begin
            run_q  <= 1'b1;
            slot_q <= SLOT_S0;
            cnt_q  <= 8'd0;
            phi1   <= 1'b1;
            phi2   <= 1'b0;
        end else if (last) begin
            if (!(slot_q == SLOT_S3 && stall)) begin
                cnt_q  <= 8'd0;
                slot_q <= slot_t'(slot_q + 2'd1);
                phi1   <= (slot_q == SLOT_S3);
                phi2   <= (slot_q == SLOT_S1);
            end
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/i4004_bus_ctrl.sv
// 4004 bus controller: CPU clocks/reset, subcycle tracking, ROM fetch and data return.
// Define I4004_BUS_STALL_EN to stretch the CPU clock until ack instead of flagging a late fetch.
module i4004_bus_ctrl
    import i4004_pkg::*;
#(
    parameter int PHASE_LEN  = 4,
    parameter int RST_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        phi1_o,
    output logic        phi2_o,
    output logic        cpu_reset_o,
    input  logic        sync_i,
    input  logic [3:0]  d_i,
    output logic [3:0]  d_o,
    output logic        d_oe_o,
    output logic        mem_req_o,
    output logic [11:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i,
    output logic [2:0]  cyc_o,
    output logic        mem_late_o
);

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    logic        phi1_rise;
    logic        phi2_rise;
    logic        stall;
    logic        ack;
    logic        late;
    logic        resync;
    logic        issue;
    logic        req_pend_q;
    logic [15:0] rst_cnt_q;
    logic [7:0]  byte_q;
    logic [7:0]  byte_nxt;
    logic [2:0]  cyc_nxt;

    i4004_clkgen #(
        .PHASE_LEN (PHASE_LEN)
    ) u_clkgen (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .stall     (stall),
        .phi1      (phi1_o),
        .phi2      (phi2_o),
        .phi1_rise (phi1_rise),
        .phi2_rise (phi2_rise)
    );

    assign ack = mem_req_o && mem_ack_i;

`ifdef I4004_BUS_STALL_EN
    assign stall = mem_req_o && !mem_ack_i && (cyc_o == CYC_M1);
    assign late  = 1'b0;
`else
    assign stall = 1'b0;
    assign late  = phi1_rise && mem_req_o && !mem_ack_i && (cyc_o == CYC_M1);
`endif

    // SYNC low is expected only at the end of X2; anywhere else the CPU has
    // been restarted under us and any fetch in flight is meaningless.
    assign resync = phi2_rise && !sync_i && (cyc_o != CYC_X2);
    assign issue  = phi2_rise && sync_i && (cyc_o == CYC_A3) && !cpu_reset_o;

    always_comb begin
        cyc_nxt = cyc_o;
        if (phi2_rise) begin
            cyc_nxt = sync_i ? cyc_o + 3'd1 : CYC_A1;
        end
        byte_nxt = byte_q;
        if (issue) begin
            byte_nxt = 8'h00;
        end else if (ack) begin
            byte_nxt = mem_data_i;
        end else if (late) begin
            byte_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_reset_o <= 1'b1;
            rst_cnt_q   <= 16'd0;
            cyc_o       <= CYC_X3;
            req_pend_q  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= 12'h000;
            byte_q      <= 8'h00;
            d_o         <= 4'h0;
            d_oe_o      <= 1'b0;
            mem_late_o  <= 1'b0;
        end else begin
            cyc_o      <= cyc_nxt;
            byte_q     <= byte_nxt;
            mem_late_o <= late;
            req_pend_q <= issue;

            if (phi1_rise && cpu_reset_o) begin
                if (rst_cnt_q == RST_LAST) begin
                    cpu_reset_o <= 1'b0;
                end
                rst_cnt_q <= rst_cnt_q + 16'd1;
            end

            if (phi2_rise && sync_i) begin
                case (cyc_o)
                    CYC_A1:  mem_addr_o[3:0]  <= d_i;
                    CYC_A2:  mem_addr_o[7:4]  <= d_i;
                    CYC_A3:  mem_addr_o[11:8] <= d_i;
                    default: ;
                endcase
            end

            if (resync || late || ack) begin
                mem_req_o <= 1'b0;
            end else if (req_pend_q) begin
                mem_req_o <= 1'b1;
            end

            d_oe_o <= (cyc_nxt == CYC_M1) || (cyc_nxt == CYC_M2);
            if (cyc_nxt == CYC_M1) begin
                d_o <= byte_nxt[7:4];
            end else if (cyc_nxt == CYC_M2) begin
                d_o <= byte_nxt[3:0];
            end else begin
                d_o <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_i4004_bus_ctrl.sv
// Directed bench for i4004_bus_ctrl: clock phases, reset length, fetch path,
// late/stall handling, resynchronisation and asynchronous reset.
module tb_i4004_bus_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        sync_i = 1'b1;
    logic [3:0]  d_i = 4'h0;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_data_i = 8'h00;
    logic        phi1_o;
    logic        phi2_o;
    logic        cpu_reset_o;
    logic [3:0]  d_o;
    logic        d_oe_o;
    logic        mem_req_o;
    logic [11:0] mem_addr_o;
    logic [2:0]  cyc_o;
    logic        mem_late_o;

    int n_chk = 0;
    int n_fail = 0;
    int late_cnt = 0;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mem_late_o === 1'b1) late_cnt++;
    end

    i4004_bus_ctrl #(
        .PHASE_LEN  (4),
        .RST_CYCLES (64)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .phi1_o      (phi1_o),
        .phi2_o      (phi2_o),
        .cpu_reset_o (cpu_reset_o),
        .sync_i      (sync_i),
        .d_i         (d_i),
        .d_o         (d_o),
        .d_oe_o      (d_oe_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .cyc_o       (cyc_o),
        .mem_late_o  (mem_late_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present SYNC/data for one CPU period and return just after the phi2 rise.
    task automatic cpu_cycle(input logic s, input logic [3:0] d);
        logic prev;
        int   n;
        sync_i = s;
        d_i    = d;
        prev   = phi2_o;
        n      = 0;
        do begin
            prev = phi2_o;
            tick();
            n++;
        end while (!(phi2_o && !prev) && n < 300);
        if (n >= 300) chk("phi2_rise_timeout", 16'({prev, phi2_o}), 16'b01);
    endtask

    initial begin
        int hi_cnt;
        int ovl_cnt;
        int req_cnt;
        int n;
        int low;
        int late_before;

        // Reset state
        #12;
        chk("rst_phi1", 16'(phi1_o), 16'd0);
        chk("rst_phi2", 16'(phi2_o), 16'd0);
        chk("rst_cpu_reset", 16'(cpu_reset_o), 16'd1);
        chk("rst_cyc", 16'(cyc_o), 16'd7);
        chk("rst_mem_req", 16'(mem_req_o), 16'd0);
        chk("rst_mem_addr", 16'(mem_addr_o), 16'd0);
        chk("rst_d_o", 16'(d_o), 16'd0);
        chk("rst_d_oe", 16'(d_oe_o), 16'd0);
        chk("rst_late", 16'(mem_late_o), 16'd0);

        // Phase pattern and CPU reset length
        @(negedge clk_i);
        rst_n_i = 1'b1;
        hi_cnt  = 0;
        ovl_cnt = 0;
        req_cnt = 0;
        n       = 0;
        do begin
            tick();
            if (n <= 16) begin
                chk($sformatf("phi1_c%0d", n), 16'(phi1_o), 16'((n % 16) < 4));
                chk($sformatf("phi2_c%0d", n), 16'(phi2_o), 16'(((n % 16) >= 8) && ((n % 16) < 12)));
            end
            if (phi1_o && phi2_o) ovl_cnt++;
            if (mem_req_o) req_cnt++;
            if (cpu_reset_o) hi_cnt++;
            n++;
        end while (cpu_reset_o && n < 2000);
        chk("phase_overlap", 16'(ovl_cnt), 16'd0);
        chk("cpu_reset_len", 16'(hi_cnt), 16'd1024);
        chk("no_fetch_in_reset", 16'(req_cnt), 16'd0);

        // Normal fetch 0x124 returning 0xD5
        cpu_cycle(1'b0, 4'h0);
        chk("resync_cyc", 16'(cyc_o), 16'd0);
        cpu_cycle(1'b1, 4'h4);
        cpu_cycle(1'b1, 4'h2);
        chk("cyc_a3", 16'(cyc_o), 16'd2);
        cpu_cycle(1'b1, 4'h1);
        chk("cyc_m1", 16'(cyc_o), 16'd3);
        chk("req_not_yet", 16'(mem_req_o), 16'd0);
        tick();
        chk("req_on", 16'(mem_req_o), 16'd1);
        chk("addr_124", 16'(mem_addr_o), 16'h124);
        mem_ack_i  = 1'b1;
        mem_data_i = 8'hD5;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        chk("req_off_after_ack", 16'(mem_req_o), 16'd0);
        chk("d_o_m1", 16'(d_o), 16'hD);
        chk("d_oe_m1", 16'(d_oe_o), 16'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = 8'h33;
        tick();
        mem_ack_i  = 1'b0;
        chk("stray_ack_ignored", 16'(d_o), 16'hD);
        cpu_cycle(1'b1, 4'h0);
        chk("d_o_m2", 16'(d_o), 16'h5);
        chk("d_oe_m2", 16'(d_oe_o), 16'd1);
        chk("no_late_on_time", 16'(late_cnt), 16'd0);
        cpu_cycle(1'b1, 4'h0);
        chk("d_o_x1", 16'(d_o), 16'h0);
        chk("d_oe_x1", 16'(d_oe_o), 16'd0);
        cpu_cycle(1'b1, 4'h0);
        cpu_cycle(1'b0, 4'h0);
        chk("wrap_cyc", 16'(cyc_o), 16'd0);

        // Slow memory: address 0x678
        cpu_cycle(1'b1, 4'h8);
        cpu_cycle(1'b1, 4'h7);
        cpu_cycle(1'b1, 4'h6);
        tick();
        chk("req_on_678", 16'(mem_req_o), 16'd1);
        chk("addr_678", 16'(mem_addr_o), 16'h678);
        late_before = late_cnt;
`ifdef I4004_BUS_STALL_EN
        n = 0;
        while (phi2_o && n < 100) begin
            tick();
            n++;
        end
        low = 0;
        while (!phi1_o && !phi2_o && low < 200) begin
            low++;
            if (low == 40) begin
                mem_ack_i  = 1'b1;
                mem_data_i = 8'hA6;
            end
            tick();
        end
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        chk("stall_low_len", 16'(low), 16'd40);
        chk("stall_phi1_after", 16'(phi1_o), 16'd1);
        chk("stall_req_off", 16'(mem_req_o), 16'd0);
        chk("stall_d_o_m1", 16'(d_o), 16'hA);
        cpu_cycle(1'b1, 4'h0);
        chk("stall_d_o_m2", 16'(d_o), 16'h6);
        chk("stall_no_late", 16'(late_cnt - late_before), 16'd0);
`else
        n = 0;
        while (!phi1_o && n < 100) begin
            tick();
            n++;
        end
        chk("deadline_cycles", 16'(n), 16'd7);
        chk("late_pulse", 16'(mem_late_o), 16'd1);
        chk("late_req_off", 16'(mem_req_o), 16'd0);
        chk("late_d_o_m1", 16'(d_o), 16'h0);
        chk("late_d_oe_m1", 16'(d_oe_o), 16'd1);
        tick();
        chk("late_pulse_end", 16'(mem_late_o), 16'd0);
        cpu_cycle(1'b1, 4'h0);
        chk("late_d_o_m2", 16'(d_o), 16'h0);
        chk("late_pulse_count", 16'(late_cnt - late_before), 16'd1);
`endif
        cpu_cycle(1'b1, 4'h0);
        cpu_cycle(1'b1, 4'h0);

        // SYNC low during M2 forces A1
        cpu_cycle(1'b0, 4'h0);
        cpu_cycle(1'b1, 4'hC);
        cpu_cycle(1'b1, 4'hB);
        cpu_cycle(1'b1, 4'hA);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = 8'h9C;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        cpu_cycle(1'b1, 4'h0);
        chk("m2_before_resync", 16'(d_o), 16'hC);
        cpu_cycle(1'b0, 4'h0);
        chk("m2_resync_cyc", 16'(cyc_o), 16'd0);
        chk("m2_resync_req", 16'(mem_req_o), 16'd0);
        chk("m2_resync_d_oe", 16'(d_oe_o), 16'd0);

        // SYNC low at the end of A3 suppresses the fetch
        cpu_cycle(1'b1, 4'h3);
        cpu_cycle(1'b1, 4'h3);
        cpu_cycle(1'b0, 4'h3);
        tick();
        chk("a3_resync_cyc", 16'(cyc_o), 16'd0);
        chk("a3_resync_no_req", 16'(mem_req_o), 16'd0);

        // Asynchronous reset in the middle of a fetch
        cpu_cycle(1'b1, 4'h1);
        cpu_cycle(1'b1, 4'h1);
        cpu_cycle(1'b1, 4'h1);
        tick();
        chk("req_before_arst", 16'(mem_req_o), 16'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_req", 16'(mem_req_o), 16'd0);
        chk("arst_cyc", 16'(cyc_o), 16'd7);
        chk("arst_cpu_reset", 16'(cpu_reset_o), 16'd1);
        chk("arst_phi1", 16'(phi1_o), 16'd0);
        chk("arst_phi2", 16'(phi2_o), 16'd0);
        chk("arst_addr", 16'(mem_addr_o), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
